// File: rtl/serial_tx_pkg.sv
// Shared serial-link definitions: FSM state encodings and default bit timing.
// The transmitter and its peer receiver both import this so their timing cannot diverge.
package serial_tx_pkg;

  localparam int DEFAULT_CLK_PER_BIT = 50;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/serial_tx.sv
// UART-style 8N1/8N2 transmitter with a one-byte holding register.
// Bytes go out LSB first at CLK_PER_BIT clocks per bit; tx, busy and idle come straight from flops.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       block,
  input  logic [7:0] data,
  input  logic       new_data,
  output logic       busy,
  output logic       idle,
  output logic       tx
);

  localparam int CTR_SIZE = $clog2(CLK_PER_BIT);
  localparam logic [CTR_SIZE-1:0] CTR_MAX = CTR_SIZE'(CLK_PER_BIT - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("serial_tx: STOP_BITS must be 1 or 2");
  end
  if (CLK_PER_BIT < 4) begin : g_bad_clk_per_bit
    $error("serial_tx: CLK_PER_BIT must be at least 4");
  end

  state_t              r_state;
  logic [CTR_SIZE-1:0] r_ctr;
  logic [2:0]          r_bit_ctr;
  logic                r_stop_ctr;
  logic [7:0]          r_shift;
  logic [7:0]          r_hold;
  logic                r_hold_full;
  logic                r_tx;
  logic                r_idle;

  state_t              w_state_next;
  logic [CTR_SIZE-1:0] w_ctr_next;
  logic [2:0]          w_bit_ctr_next;
  logic                w_stop_ctr_next;
  logic [7:0]          w_shift_next;
  logic [7:0]          w_hold_next;
  logic                w_hold_full_next;
  logic                w_ctr_tc;
  logic                w_load;

  always_comb begin
    w_state_next     = r_state;
    w_ctr_next       = r_ctr;
    w_bit_ctr_next   = r_bit_ctr;
    w_stop_ctr_next  = r_stop_ctr;
    w_shift_next     = r_shift;
    w_hold_next      = r_hold;
    w_hold_full_next = r_hold_full;
    w_ctr_tc         = (r_ctr == CTR_MAX);
    w_load           = 1'b0;

    if (r_state != ST_IDLE) begin
      w_ctr_next = w_ctr_tc ? '0 : r_ctr + CTR_SIZE'(1);
    end

    case (r_state)
      ST_IDLE: begin
        w_load = r_hold_full && !block;
      end
      ST_START: begin
        if (w_ctr_tc) begin
          w_state_next   = ST_DATA;
          w_bit_ctr_next = 3'd0;
        end
      end
      ST_DATA: begin
        if (w_ctr_tc) begin
          w_shift_next   = {1'b0, r_shift[7:1]};
          w_bit_ctr_next = r_bit_ctr + 3'd1;
          if (r_bit_ctr == 3'd7) begin
            w_state_next    = ST_STOP;
            w_stop_ctr_next = 1'b0;
          end
        end
      end
      default: begin
        // Last stop period: chain straight into the next frame when a byte is waiting.
        if (w_ctr_tc) begin
          if (r_stop_ctr == 1'(STOP_BITS - 1)) begin
            w_load = r_hold_full && !block;
            if (!(r_hold_full && !block)) begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_stop_ctr_next = 1'b1;
          end
        end
      end
    endcase

    if (w_load) begin
      w_state_next     = ST_START;
      w_shift_next     = r_hold;
      w_hold_full_next = 1'b0;
      w_ctr_next       = '0;
    end

    // Load needs hold_full and accept needs it clear, so the two never collide.
    if (new_data && !r_hold_full) begin
      w_hold_next      = data;
      w_hold_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ctr       <= '0;
      r_bit_ctr   <= 3'd0;
      r_stop_ctr  <= 1'b0;
      r_shift     <= 8'd0;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_tx        <= 1'b1;
      r_idle      <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_ctr       <= w_ctr_next;
      r_bit_ctr   <= w_bit_ctr_next;
      r_stop_ctr  <= w_stop_ctr_next;
      r_shift     <= w_shift_next;
      r_hold      <= w_hold_next;
      r_hold_full <= w_hold_full_next;
      // Line and idle flag follow the state one clock later, so idle rises as the last stop bit ends.
      r_tx        <= (r_state == ST_START) ? 1'b0 :
                     (r_state == ST_DATA)  ? r_shift[0] : 1'b1;
      r_idle      <= (r_state == ST_IDLE) && !r_hold_full;
    end
  end

  assign busy = r_hold_full;
  assign idle = r_idle;
  assign tx   = r_tx;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx at CLK_PER_BIT=8: one STOP_BITS=1 and one STOP_BITS=2 instance on shared stimulus.
module tb_serial_tx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       block = 1'b0;
  logic       new_data = 1'b0;
  logic [7:0] data = 8'd0;
  logic       busy, idle, tx;
  logic       busy2, idle2, tx2;

  int checks = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  int         rx_ferr = 0;
  logic       rx_active = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_byte = 8'd0;

  serial_tx #(.CLK_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .block(block), .data(data), .new_data(new_data),
    .busy(busy), .idle(idle), .tx(tx)
  );

  serial_tx #(.CLK_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .block(block), .data(data), .new_data(new_data),
    .busy(busy2), .idle(idle2), .tx(tx2)
  );

  always #5 clk = ~clk;

  // Peer receiver: first low sample is t=0, data bits sampled mid-bit, stop bit at t=76.
  always @(negedge clk) begin
    if (!rst) begin
      rx_active <= 1'b0;
      rx_t      <= 0;
    end else if (!rx_active) begin
      if (tx == 1'b0) begin
        rx_active <= 1'b1;
        rx_t      <= 1;
      end
    end else begin
      if (rx_t >= 12 && rx_t <= 68 && ((rx_t - 12) % 8) == 0) rx_byte <= {tx, rx_byte[7:1]};
      if (rx_t == 76) begin
        if (tx !== 1'b1) rx_ferr <= rx_ferr + 1;
        rx_q.push_back(rx_byte);
      end
      if (rx_t == 79) rx_active <= 1'b0;
      else rx_t <= rx_t + 1;
    end
  end

  // Line level t cycles after the start bit falls (8 cycles per bit, stop/idle high).
  function automatic logic exp_level(input logic [7:0] b, input int t);
    if (t < 0) return 1'b1;
    if (t < 8) return 1'b0;
    if (t < 72) return b[(t - 8) / 8];
    return 1'b1;
  endfunction

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    data = b;
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(idle === 1'b1 && idle2 === 1'b1 && busy === 1'b0 && busy2 === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(idle === 1'b1 && idle2 === 1'b1 && busy === 1'b0 && busy2 === 1'b0)) begin
      failures++;
      $display("FAIL wait_idle: idle=%b idle2=%b busy=%b busy2=%b after %0d cycles, required 1 1 0 0",
               idle, idle2, busy, busy2, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic e;
    int t;
    @(negedge clk);
    checks++;
    if ({tx, busy, idle, tx2} !== 4'b1011) begin
      failures++;
      $display("FAIL reset_state: tx,busy,idle,tx2=%b required 1011", {tx, busy, idle, tx2});
    end
    @(negedge clk);
    rst = 1'b1;
    strobe(8'h00);
    @(negedge clk);
    @(negedge clk);
    data = 8'h55;
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
    repeat (26) @(negedge clk);
    checks++;
    if ({tx, busy} !== 2'b01) begin
      failures++;
      $display("FAIL reset_pre_data: tx,busy=%b required 01", {tx, busy});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({tx, busy, idle} !== 3'b101) begin
      failures++;
      $display("FAIL reset_async: tx,busy,idle=%b required 101", {tx, busy, idle});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, idle} !== 3'b101) begin
        failures++;
        $display("FAIL reset_held_lost: cycle %0d tx,busy,idle=%b required 101", i, {tx, busy, idle});
      end
    end
    strobe(8'h3C);
    for (int n = 2; n <= 86; n++) begin
      @(negedge clk);
      t = n - 3;
      e = exp_level(8'h3C, t);
      checks++;
      if (tx !== e) begin
        failures++;
        $display("FAIL reset_reframe_tx: n=%0d tx=%b required %b", n, tx, e);
      end
      e = (t >= 80);
      checks++;
      if (idle !== e) begin
        failures++;
        $display("FAIL reset_reframe_idle: n=%0d idle=%b required %b", n, idle, e);
      end
    end
  endtask

  task automatic test_single_a5();
    logic a5_lv[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic e;
    int t;
    wait_idle(400);
    strobe(8'hA5);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL a5_busy_accept: busy=%b required 1", busy);
    end
    for (int n = 2; n <= 90; n++) begin
      @(negedge clk);
      t = n - 3;
      e = (t >= 0 && t < 80) ? a5_lv[t / 8] : 1'b1;
      checks++;
      if (tx !== e) begin
        failures++;
        $display("FAIL a5_tx: n=%0d tx=%b required %b", n, tx, e);
      end
      e = (t >= 80);
      checks++;
      if (idle !== e || busy !== 1'b0) begin
        failures++;
        $display("FAIL a5_idle_busy: n=%0d idle=%b busy=%b required idle=%b busy=0", n, idle, busy, e);
      end
    end
  endtask

  task automatic test_back_to_back_overrun();
    logic e;
    int t;
    wait_idle(400);
    strobe(8'h00);
    for (int n = 2; n <= 200; n++) begin
      @(negedge clk);
      t = n - 3;
      e = (t < 80) ? exp_level(8'h00, t) : exp_level(8'hFF, t - 80);
      checks++;
      if (tx !== e) begin
        failures++;
        $display("FAIL b2b_tx: n=%0d tx=%b required %b", n, tx, e);
      end
      e = (n >= 4 && n <= 81);
      checks++;
      if (busy !== e) begin
        failures++;
        $display("FAIL b2b_busy: n=%0d busy=%b required %b", n, busy, e);
      end
      e = (t >= 160);
      checks++;
      if (idle !== e) begin
        failures++;
        $display("FAIL b2b_idle: n=%0d idle=%b required %b", n, idle, e);
      end
      if (n == 3) begin data = 8'hFF; new_data = 1'b1; end
      if (n == 4) new_data = 1'b0;
      if (n == 10) begin data = 8'h33; new_data = 1'b1; end
      if (n == 11) new_data = 1'b0;
    end
  endtask

  task automatic test_block();
    logic e;
    int t;
    wait_idle(400);
    strobe(8'h5A);
    for (int n = 2; n <= 195; n++) begin
      @(negedge clk);
      t = n - 3;
      e = (n < 104) ? ((t < 80) ? exp_level(8'h5A, t) : 1'b1) : exp_level(8'hC3, n - 104);
      checks++;
      if (tx !== e) begin
        failures++;
        $display("FAIL block_tx: n=%0d tx=%b required %b", n, tx, e);
      end
      e = (n >= 4 && n <= 102);
      checks++;
      if (busy !== e) begin
        failures++;
        $display("FAIL block_busy: n=%0d busy=%b required %b", n, busy, e);
      end
      e = (n >= 184);
      checks++;
      if (idle !== e) begin
        failures++;
        $display("FAIL block_idle: n=%0d idle=%b required %b", n, idle, e);
      end
      if (n == 3) begin data = 8'hC3; new_data = 1'b1; end
      if (n == 4) new_data = 1'b0;
      if (n == 20) block = 1'b1;
      if (n == 102) block = 1'b0;
    end
  endtask

  task automatic test_two_stop();
    logic e;
    int t;
    wait_idle(600);
    strobe(8'h96);
    for (int n = 2; n <= 185; n++) begin
      @(negedge clk);
      t = n - 3;
      e = (t < 88) ? exp_level(8'h96, t) : exp_level(8'h01, t - 88);
      checks++;
      if (tx2 !== e) begin
        failures++;
        $display("FAIL stop2_tx: n=%0d tx2=%b required %b", n, tx2, e);
      end
      e = (t >= 176);
      checks++;
      if (idle2 !== e) begin
        failures++;
        $display("FAIL stop2_idle: n=%0d idle2=%b required %b", n, idle2, e);
      end
      if (n == 3) begin data = 8'h01; new_data = 1'b1; end
      if (n == 4) new_data = 1'b0;
    end
  endtask

  task automatic test_loopback();
    logic [7:0] sent[$];
    logic [7:0] b;
    int base;
    int ferr0;
    int w;
    bit timed_out;
    wait_idle(600);
    base = rx_q.size();
    ferr0 = rx_ferr;
    timed_out = 0;
    for (int i = 0; i < 256 && !timed_out; i++) begin
      w = 0;
      while (busy && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (busy) begin
        timed_out = 1;
        checks++;
        failures++;
        $display("FAIL loop_busy_timeout: byte %0d busy=%b required 0 within 200 cycles", i, busy);
      end else begin
        b = 8'($urandom_range(0, 255));
        sent.push_back(b);
        data = b;
        new_data = 1'b1;
        @(negedge clk);
        new_data = 1'b0;
      end
    end
    wait_idle(400);
    checks++;
    if (rx_q.size() - base != 256) begin
      failures++;
      $display("FAIL loop_count: received %0d bytes required 256", rx_q.size() - base);
    end
    for (int i = 0; i < sent.size() && base + i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[base + i] !== sent[i]) begin
        failures++;
        $display("FAIL loop_data: byte %0d got %02h required %02h", i, rx_q[base + i], sent[i]);
      end
    end
    checks++;
    if (rx_ferr != ferr0) begin
      failures++;
      $display("FAIL loop_framing: stop-bit errors %0d required 0", rx_ferr - ferr0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back_overrun();
    test_block();
    test_two_stop();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
